// File: rtl/mio_arbiter.sv
// mio_arbiter: shares one memory/IO bus between the CPU controller and an
// auxiliary master (DMA/debug loader). One access at a time:
// IDLE -> ACCESS (WAIT_CYC cycles) -> DONE (one-cycle ready pulse) -> IDLE.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests instead of
// fixed CPU priority.
module mio_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       we_q;
  logic       any_req;
  logic       pick_aux;

`ifdef ARB_RR_EN
  // Owner of the most recent access; resets to aux so the first tie goes to CPU.
  logic       last_grant;

  // Round-robin winner: a sole requester always wins, a tie goes to the
  // master that was not granted last.
  always_comb begin
    any_req  = cpu_req | aux_req;
    pick_aux = aux_req & (~cpu_req | ~last_grant);
  end

  // Remember the owner of each new access for the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick_aux;
    end
  end
`else
  // Fixed priority winner: CPU takes every tie.
  always_comb begin
    any_req  = cpu_req | aux_req;
    pick_aux = aux_req & ~cpu_req;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and per-master read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      grant     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      aux_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick_aux;
            we_q      <= pick_aux ? aux_we    : cpu_we;
            mem_addr  <= pick_aux ? aux_addr  : cpu_addr;
            mem_wdata <= pick_aux ? aux_wdata : cpu_wdata;
            cnt       <= 4'(WAIT_CYC - 1);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            if (grant) aux_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus strobes and handshake outputs decoded from the state.
  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) & we_q;
    busy      = (state != IDLE);
    cpu_ready = (state == DONE) & ~grant;
    aux_ready = (state == DONE) & grant;
  end

endmodule
